// File: rtl/alarm_ringer.sv
// alarm_ringer: compares the packed alarm word against calendar time each second,
// rings a 1 Hz buzzer with stop/snooze/auto-snooze handling, and pulses rst_alarm when finished.
module alarm_ringer #(
    parameter int RING_SECS   = 30,
    parameter int SNOOZE_SECS = 300,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clk1sec,
    input  logic        rst,
    input  logic [13:0] year,
    input  logic [7:0]  month,
    input  logic [7:0]  day,
    input  logic [7:0]  hour,
    input  logic [7:0]  min,
    input  logic [7:0]  sec,
    input  logic [51:0] transfer_alarm,
    input  logic        stop_req,
    input  logic        snooze_req,
    output logic        ringing,
    output logic        buzz,
    output logic        snoozing,
    output logic [2:0]  snooze_cnt,
    output logic [9:0]  remaining,
    output logic        rst_alarm
);
    typedef enum logic [2:0] {IDLE, ARMED, RINGING, SNOOZE, DONE} state_t;

    localparam logic [9:0] RING_INIT   = 10'(RING_SECS);
    localparam logic [9:0] SNOOZE_INIT = 10'(SNOOZE_SECS);
    localparam logic [2:0] MAX_CNT     = 3'(MAX_SNOOZE);

    state_t r_state;
    logic   r_stop_prev;
    logic   r_snooze_prev;
    logic   w_stop_edge;
    logic   w_snooze_edge;
    logic   w_cancel;
    logic   w_match;
    logic   w_can_snooze;
    logic   w_last_sec;

    assign w_stop_edge   = stop_req & ~r_stop_prev;
    assign w_snooze_edge = snooze_req & ~r_snooze_prev;
    assign w_cancel      = transfer_alarm == '0;
    assign w_match       = ({year, month, day, hour, min, sec} == transfer_alarm) && !w_cancel;
    assign w_can_snooze  = snooze_cnt < MAX_CNT;
    assign w_last_sec    = remaining == 10'd1;

    always_ff @(posedge clk1sec or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_stop_prev   <= 1'b0;
            r_snooze_prev <= 1'b0;
            ringing       <= 1'b0;
            buzz          <= 1'b0;
            snoozing      <= 1'b0;
            snooze_cnt    <= 3'd0;
            remaining     <= 10'd0;
            rst_alarm     <= 1'b0;
        end else begin
            r_stop_prev   <= stop_req;
            r_snooze_prev <= snooze_req;
            rst_alarm     <= 1'b0;
            case (r_state)
                IDLE: if (!w_cancel) r_state <= ARMED;
                ARMED: begin
                    if (w_cancel) begin
                        r_state <= IDLE;
                    end else if (w_match) begin
                        r_state    <= RINGING;
                        ringing    <= 1'b1;
                        buzz       <= 1'b1;
                        remaining  <= RING_INIT;
                        snooze_cnt <= 3'd0;
                    end
                end
                RINGING, SNOOZE: begin
                    // Leaving either active phase clears every output; DONE also raises the pulse.
                    if (w_cancel || w_stop_edge
                        || (r_state == RINGING && w_last_sec && !w_can_snooze)) begin
                        r_state    <= w_cancel ? IDLE : DONE;
                        rst_alarm  <= !w_cancel;
                        ringing    <= 1'b0;
                        buzz       <= 1'b0;
                        snoozing   <= 1'b0;
                        remaining  <= 10'd0;
                        snooze_cnt <= 3'd0;
                    end else if (r_state == RINGING && w_can_snooze && (w_snooze_edge || w_last_sec)) begin
                        r_state    <= SNOOZE;
                        ringing    <= 1'b0;
                        buzz       <= 1'b0;
                        snoozing   <= 1'b1;
                        remaining  <= SNOOZE_INIT;
                        snooze_cnt <= snooze_cnt + 3'd1;
                    end else if (r_state == SNOOZE && w_last_sec) begin
                        r_state   <= RINGING;
                        ringing   <= 1'b1;
                        buzz      <= 1'b1;
                        snoozing  <= 1'b0;
                        remaining <= RING_INIT;
                    end else begin
                        remaining <= remaining - 10'd1;
                        buzz      <= ringing ? ~buzz : 1'b0;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer: directed stimulus with an elapsed-time reference model checked every
// falling clock edge, plus literal expectations at the key points of each scenario.
module tb_alarm_ringer;
    localparam int RS = 5;
    localparam int SS = 3;
    localparam int MX = 2;
    localparam logic [51:0] ALARM = {14'd2024, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};

    logic        clk1sec = 1'b0;
    logic        rst;
    logic [13:0] t_year;
    logic [7:0]  t_month, t_day, t_hour, t_min, t_sec;
    logic [51:0] t_alarm;
    logic        stop_req, snooze_req;
    logic        ringing, buzz, snoozing, rst_alarm;
    logic [2:0]  snooze_cnt;
    logic [9:0]  remaining;

    int n_chk = 0;
    int n_fail = 0;

    alarm_ringer #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MX)) dut (
        .clk1sec(clk1sec), .rst(rst),
        .year(t_year), .month(t_month), .day(t_day), .hour(t_hour), .min(t_min), .sec(t_sec),
        .transfer_alarm(t_alarm), .stop_req(stop_req), .snooze_req(snooze_req),
        .ringing(ringing), .buzz(buzz), .snoozing(snoozing),
        .snooze_cnt(snooze_cnt), .remaining(remaining), .rst_alarm(rst_alarm)
    );

    always #5 clk1sec = ~clk1sec;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase plus seconds elapsed within the phase.
    localparam int P_IDLE = 0, P_ARMED = 1, P_RING = 2, P_SNZ = 3, P_DONE = 4;
    int m_ph = P_IDLE;
    int m_age = 0;
    int m_cnt = 0;
    bit m_ps = 0, m_pz = 0;

    initial forever begin
        @(posedge clk1sec or negedge rst);
        if (!rst) begin
            m_ph = P_IDLE; m_age = 0; m_cnt = 0; m_ps = 0; m_pz = 0;
        end else begin
            bit se, ze, gone, hit;
            se = stop_req && !m_ps;
            ze = snooze_req && !m_pz;
            m_ps = stop_req;
            m_pz = snooze_req;
            gone = t_alarm == 0;
            hit = !gone && ({t_year, t_month, t_day, t_hour, t_min, t_sec} == t_alarm);
            if (m_ph == P_IDLE) begin
                if (!gone) m_ph = P_ARMED;
            end else if (m_ph == P_ARMED) begin
                if (gone) m_ph = P_IDLE;
                else if (hit) begin m_ph = P_RING; m_age = 0; m_cnt = 0; end
            end else if (m_ph == P_DONE) begin
                m_ph = P_IDLE;
            end else if (gone) begin
                m_ph = P_IDLE; m_cnt = 0;
            end else if (se) begin
                m_ph = P_DONE; m_cnt = 0;
            end else if (m_ph == P_RING) begin
                if ((ze && m_cnt < MX) || (m_age == RS - 1 && m_cnt < MX)) begin
                    m_ph = P_SNZ; m_age = 0; m_cnt++;
                end else if (m_age == RS - 1) begin
                    m_ph = P_DONE; m_cnt = 0;
                end else m_age++;
            end else begin
                if (m_age == SS - 1) begin m_ph = P_RING; m_age = 0; end
                else m_age++;
            end
        end
    end

    initial forever begin
        @(negedge clk1sec);
        chk("model_ringing", int'(ringing), int'(m_ph == P_RING));
        chk("model_buzz", int'(buzz), int'(m_ph == P_RING && m_age % 2 == 0));
        chk("model_snoozing", int'(snoozing), int'(m_ph == P_SNZ));
        chk("model_snooze_cnt", int'(snooze_cnt), m_cnt);
        chk("model_remaining", int'(remaining),
            m_ph == P_RING ? RS - m_age : m_ph == P_SNZ ? SS - m_age : 0);
        chk("model_rst_alarm", int'(rst_alarm), int'(m_ph == P_DONE));
    end

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk1sec);
        #1;
    endtask

    task automatic expect_outs(input string name, input int r, input int b, input int s,
                               input int c, input int rem, input int ra);
        chk({name, ".ringing"}, int'(ringing), r);
        chk({name, ".buzz"}, int'(buzz), b);
        chk({name, ".snoozing"}, int'(snoozing), s);
        chk({name, ".snooze_cnt"}, int'(snooze_cnt), c);
        chk({name, ".remaining"}, int'(remaining), rem);
        chk({name, ".rst_alarm"}, int'(rst_alarm), ra);
    endtask

    initial begin
        rst = 1'b0; stop_req = 1'b0; snooze_req = 1'b0; t_alarm = '0;
        t_year = 14'd2024; t_month = 8'd5; t_day = 8'd6; t_hour = 8'd7; t_min = 8'd8; t_sec = 8'd0;
        #1 expect_outs("reset", 0, 0, 0, 0, 0, 0);
        #10 rst = 1'b1;
        t_alarm = ALARM; t_sec = 8'd7;
        cyc(); expect_outs("armed", 0, 0, 0, 0, 0, 0);
        t_sec = 8'd8;
        cyc(); expect_outs("no_match", 0, 0, 0, 0, 0, 0);
        t_sec = 8'd9;
        cyc(); expect_outs("match", 1, 1, 0, 0, 5, 0);
        t_sec = 8'd10;
        cyc(); expect_outs("buzz_0", 1, 0, 0, 0, 4, 0);
        cyc(); expect_outs("buzz_1", 1, 1, 0, 0, 3, 0);
        cyc(); expect_outs("buzz_2", 1, 0, 0, 0, 2, 0);
        cyc(); expect_outs("buzz_3", 1, 1, 0, 0, 1, 0);
        cyc(); expect_outs("timeout_snz1", 0, 0, 1, 1, 3, 0);
        cyc(3); expect_outs("ring2", 1, 1, 0, 1, 5, 0);
        cyc(5); expect_outs("timeout_snz2", 0, 0, 1, 2, 3, 0);
        cyc(3); expect_outs("ring3", 1, 1, 0, 2, 5, 0);
        cyc(5); expect_outs("exhaust_done", 0, 0, 0, 0, 0, 1);
        cyc(); expect_outs("exhaust_idle", 0, 0, 0, 0, 0, 0);
        cyc();
        t_sec = 8'd9;
        cyc(); expect_outs("stop_ring", 1, 1, 0, 0, 5, 0);
        t_sec = 8'd10;
        cyc(2); expect_outs("stop_third", 1, 1, 0, 0, 3, 0);
        stop_req = 1'b1;
        cyc(); expect_outs("stop_done", 0, 0, 0, 0, 0, 1);
        cyc(); expect_outs("stop_idle", 0, 0, 0, 0, 0, 0);
        cyc(); expect_outs("stop_once", 0, 0, 0, 0, 0, 0);
        stop_req = 1'b0;
        t_sec = 8'd9;
        cyc(); expect_outs("snz_ring", 1, 1, 0, 0, 5, 0);
        t_sec = 8'd10; snooze_req = 1'b1;
        cyc(); expect_outs("snooze", 0, 0, 1, 1, 3, 0);
        snooze_req = 1'b0;
        cyc();
        snooze_req = 1'b1;
        cyc(); expect_outs("snooze_ignored", 0, 0, 1, 1, 1, 0);
        snooze_req = 1'b0;
        cyc(); expect_outs("snooze_end", 1, 1, 0, 1, 5, 0);
        snooze_req = 1'b1;
        cyc(); expect_outs("snooze_2", 0, 0, 1, 2, 3, 0);
        snooze_req = 1'b0;
        cyc(3);
        snooze_req = 1'b1;
        cyc(); expect_outs("snooze_sat", 1, 0, 0, 2, 4, 0);
        snooze_req = 1'b0;
        cyc();
        stop_req = 1'b1; snooze_req = 1'b1;
        cyc(); expect_outs("stop_wins", 0, 0, 0, 0, 0, 1);
        stop_req = 1'b0; snooze_req = 1'b0;
        cyc(2);
        t_sec = 8'd9;
        cyc();
        t_sec = 8'd10; snooze_req = 1'b1;
        cyc(); expect_outs("cancel_snz", 0, 0, 1, 1, 3, 0);
        snooze_req = 1'b0; t_alarm = '0;
        cyc(); expect_outs("cancel", 0, 0, 0, 0, 0, 0);
        cyc(); expect_outs("cancel_nopulse", 0, 0, 0, 0, 0, 0);
        t_alarm = ALARM;
        cyc();
        t_sec = 8'd9;
        cyc(); expect_outs("rst_ring", 1, 1, 0, 0, 5, 0);
        t_sec = 8'd10;
        cyc();
        #2 rst = 1'b0;
        #1 expect_outs("async_reset", 0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        cyc(); expect_outs("rst_armed", 0, 0, 0, 0, 0, 0);
        cyc(); expect_outs("no_ring_after_reset", 0, 0, 0, 0, 0, 0);
        t_sec = 8'd9;
        cyc(); expect_outs("rearm_match", 1, 1, 0, 0, 5, 0);
        t_sec = 8'd10;
        cyc(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alarm_ringer.md
# alarm_ringer

Consumer end of the alarm-setting path. Takes the packed 52-bit alarm word produced by the alarm-setting/LCD mode block and compares it every second against the running calendar time. On a match it drives a buzzer with a 1 Hz pattern, handles stop and snooze requests, and auto-snoozes on timeout. When the alarm is finished it returns a one-period `rst_alarm` pulse that clears the setting in the setting block.

## Interface
- `RING_SECS`, default 30: length of one ringing burst, in seconds. Legal range 1..1023.
- `SNOOZE_SECS`, default 300: snooze duration, in seconds. Legal range 1..1023.
- `MAX_SNOOZE`, default 3: maximum number of snoozes before the alarm is forcibly finished. Legal range 0..7.
- `clk1sec`  in  1  1 Hz clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `year`  in  14  current year, binary.
- `month`, `day`, `hour`, `min`, `sec`  in  8 each  current time fields, binary.
- `transfer_alarm`  in  52  packed alarm word `{year[13:0], month, day, hour, min, sec}`. Value 0 means no alarm set.
- `stop_req`  in  1  level; user stop request, held for at least one clk1sec period.
- `snooze_req`  in  1  level; user snooze request, held for at least one clk1sec period.
- `ringing`  out  1  high while in the RINGING state.
- `buzz`  out  1  buzzer drive; toggles each second while ringing.
- `snoozing`  out  1  high while in the SNOOZE state.
- `snooze_cnt`  out  3  number of snoozes taken in the current alarm event.
- `remaining`  out  10  seconds left in the current RINGING or SNOOZE phase; 0 otherwise.
- `rst_alarm`  out  1  one-clk1sec-period pulse requesting that the alarm setting be cleared.

## Operation
- All outputs are registered.
- Reset values: state IDLE; `ringing`, `buzz`, `snoozing`, `rst_alarm` = 0; `snooze_cnt` = 0; `remaining` = 0.
- Requests are rising-edge detected: `stop_req` and `snooze_req` are sampled into prev registers (reset 0), and an edge is `req & ~prev`. A request held high counts once.
- `match` = (`{year, month, day, hour, min, sec}` == `transfer_alarm`) && (`transfer_alarm` != 0).
- States:
  - **IDLE:** `transfer_alarm` != 0 → ARMED.
  - **ARMED:** `transfer_alarm` == 0 → IDLE. Else `match` → RINGING with `remaining` = RING_SECS, `buzz` = 1, `snooze_cnt` = 0. A new `transfer_alarm` value is compared directly; there is no re-arm latency.
  - **RINGING:** priority order is cancel > stop > snooze > timeout.
    - Cancel: `transfer_alarm` == 0 → IDLE, no pulse.
    - Stop edge → DONE.
    - Snooze edge with `snooze_cnt` < MAX_SNOOZE → SNOOZE with `remaining` = SNOOZE_SECS and `snooze_cnt`+1.
    - Snooze edge with `snooze_cnt` == MAX_SNOOZE → ignored.
    - Timeout: `remaining` == 1 with no event → SNOOZE with count+1 if `snooze_cnt` < MAX_SNOOZE, else DONE.
    - Otherwise `remaining`−1 and `buzz` toggles.
  - **SNOOZE:**
    - Cancel → IDLE.
    - Stop edge → DONE.
    - Snooze edge ignored.
    - `remaining` == 1 → RINGING with `remaining` = RING_SECS, `buzz` = 1.
    - Otherwise `remaining`−1.
  - **DONE:** `rst_alarm` = 1 for exactly this one cycle, all other outputs 0, `snooze_cnt` cleared. Next cycle → IDLE unconditionally. Because IDLE requires `transfer_alarm` != 0 to re-arm, the stale setting cannot re-fire before the clear lands. If it is still nonzero, the next ARMED compare needs the time to match again, which cannot happen within one second.
- `ringing` = (state == RINGING). `snoozing` = (state == SNOOZE).
- `buzz` = 0 outside RINGING.
- `remaining` = 0 in IDLE, ARMED and DONE.
- Width rules:
  - `remaining` is 10-bit unsigned and never underflows; the transition is taken at 1.
  - `snooze_cnt` is 3-bit and saturates at MAX_SNOOZE.

## Timing
- Match latency: if the inputs equal the alarm word at edge k (state ARMED), then `ringing` and `buzz` are 1 after edge k.
- A RINGING burst lasts exactly RING_SECS cycles. A SNOOZE lasts exactly SNOOZE_SECS cycles.
- A stop edge sampled at edge k in RINGING/SNOOZE gives DONE after edge k (`rst_alarm` = 1), then IDLE after edge k+1.
- `stop_req` and `snooze_req` rising in the same period: stop wins.
- Reset asserted mid-ring: all outputs go to reset values immediately (asynchronous), with no `rst_alarm` pulse.
- Time inputs may change between clk1sec edges; only the value at the edge matters.

## Test plan
- **Match and ring.** Alarm 2024/05/06 07:08:09, time stepped up to it → `ringing` rises after the matching edge; `buzz` reads 1,0,1,0 on successive cycles; `remaining` counts down from 30.
- **Stop.** RING_SECS=5; stop edge in the 3rd ringing cycle → one cycle with `rst_alarm`=1, `ringing`=0, then IDLE; holding `stop_req` high for 3 s produces only one DONE.
- **Snooze cycle.** SNOOZE_SECS=3, MAX_SNOOZE=2; snooze edge while ringing → `snoozing`=1 for exactly 3 cycles, `snooze_cnt`=1, then ringing again; a further snooze edge during SNOOZE is ignored.
- **Timeout exhaustion.** RING_SECS=2, SNOOZE_SECS=2, MAX_SNOOZE=2, no user input → ring 2, snooze 2, ring 2, snooze 2, ring 2, then `rst_alarm` pulse; `snooze_cnt` reaches 2, then clears.
- **Cancel and simultaneous requests.** `transfer_alarm` forced to 0 mid-snooze → IDLE with no pulse. Stop and snooze rising in the same period while ringing → DONE.
- **Reset.** `rst` low mid-ring → all outputs 0 immediately; after release with `transfer_alarm` nonzero → ARMED, with no ringing until the next match.
